// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand4_bist_if.sv
// Bus between the NAND4 BIST controller and whoever drives it: control
// requests in, stimulus to the cell under test out, observed cell output in,
// and the result registers out.
//
// Handshake: START is a level request. It is accepted on a rising CLK edge
// only when the controller is not BUSY (IDLE or DONE) and ABORT is low;
// acceptance shows up as BUSY=1 after that edge. DONE acts as the valid for
// PASS/ERRCNT/FAIL_VLD/FAIL_VEC. Those results hold until the next accepted
// START, an ABORT, or reset. ABORT wins over everything at the edge it is
// seen.
interface gf180mcu_fd_sc_mcu9t5v0__nand4_bist_if;
  logic       START;
  logic       ABORT;
  logic       ZN_IN;
  logic       A1;
  logic       A2;
  logic       A3;
  logic       A4;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [4:0] ERRCNT;
  logic       FAIL_VLD;
  logic [3:0] FAIL_VEC;
  logic [1:0] STATE_DBG;

  modport master (
    output START, ABORT, ZN_IN,
    input  A1, A2, A3, A4, BUSY, DONE, PASS, ERRCNT, FAIL_VLD, FAIL_VEC,
           STATE_DBG
  );

  modport slave (
    input  START, ABORT, ZN_IN,
    output A1, A2, A3, A4, BUSY, DONE, PASS, ERRCNT, FAIL_VLD, FAIL_VEC,
           STATE_DBG
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand4_bist.sv
// Exhaustive built-in self test for a 4-input NAND cell. It walks all 16
// input vectors and holds each for SETTLE cycles. At the end of each hold
// window it samples the cell output and compares it with ~&A. It counts
// mismatches and latches the first failing vector. Every output comes
// straight from a flop.
module gf180mcu_fd_sc_mcu9t5v0__nand4_bist #(
  parameter int SETTLE = 2  // hold cycles per vector, legal 1..15
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu9t5v0__nand4_bist_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] V_LAST      = 4'hF;

  // Supply pins carry no logic; fold them into a sink so they are referenced.
  wire unused_supply = VDD ^ VSS;

  state_t     state_q, state_d;
  logic [3:0] v_q, v_d;            // vector index under test
  logic [3:0] cnt_q, cnt_d;        // cycles spent on the current vector
  logic [3:0] a_q, a_d;            // registered stimulus {A4,A3,A2,A1}
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] errcnt_q, errcnt_d;
  logic       fail_vld_q, fail_vld_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  logic       sample_due;
  logic       exp_zn;
  logic       mismatch;

  // Next-state, vector sequencing and result capture.
  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    errcnt_d   = errcnt_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;

    sample_due = (cnt_q == SETTLE_LAST);
    exp_zn     = ~&v_q;
    mismatch   = (bus.ZN_IN != exp_zn);

    if (bus.ABORT) begin
      // Cancel from any state. The results of the cancelled run stay visible.
      state_d = ST_IDLE;
      v_d     = 4'd0;
      cnt_d   = 4'd0;
      a_d     = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state_d    = ST_RUN;
            v_d        = 4'd0;
            cnt_d      = 4'd0;
            a_d        = 4'd0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            errcnt_d   = 5'd0;
            fail_vld_d = 1'b0;
            fail_vec_d = 4'd0;
          end
        end
        ST_RUN: begin
          if (sample_due) begin
            cnt_d = 4'd0;
            if (mismatch) begin
              errcnt_d = errcnt_q + 5'd1;
              if (!fail_vld_q) begin
                fail_vld_d = 1'b1;
                fail_vec_d = v_q;
              end
            end
            if (v_q == V_LAST) begin
              // Final sample: park the stimulus and publish the verdict.
              state_d = ST_DONE;
              v_d     = 4'd0;
              a_d     = 4'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (errcnt_q == 5'd0) && !mismatch;
            end else begin
              v_d = v_q + 4'd1;
              a_d = v_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          v_d     = 4'd0;
          cnt_d   = 4'd0;
          a_d     = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // State and result registers; reset clears everything without a clock.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      v_q        <= 4'd0;
      cnt_q      <= 4'd0;
      a_q        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errcnt_q   <= 5'd0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      errcnt_q   <= errcnt_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign bus.A1        = a_q[0];
  assign bus.A2        = a_q[1];
  assign bus.A3        = a_q[2];
  assign bus.A4        = a_q[3];
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.ERRCNT    = errcnt_q;
  assign bus.FAIL_VLD  = fail_vld_q;
  assign bus.FAIL_VEC  = fail_vec_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nand4_bist.sv
// Bench for the NAND4 BIST controller. There are three instances, with
// SETTLE = 1, 2 and 3. Each instance sees a simulated cell whose response
// comes from a 16-entry truth table, so faults are just flipped table bits.
module tb_gf180mcu_fd_sc_mcu9t5v0__nand4_bist;

  localparam int          N_INST = 3;
  localparam logic [15:0] IDEAL  = 16'h7FFF;  // bit v = ~&v

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] cyc;
    logic        pass;
    logic [4:0]  errcnt;
    logic        fail_vld;
    logic [3:0]  fail_vec;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [N_INST-1:0] start_r;
  logic [N_INST-1:0] abort_r;
  logic [15:0]       resp_tab [N_INST];

  logic [3:0]        a_o        [N_INST];
  logic [N_INST-1:0] busy_o;
  logic [N_INST-1:0] done_o;
  logic [N_INST-1:0] pass_o;
  logic [4:0]        errcnt_o   [N_INST];
  logic [N_INST-1:0] fail_vld_o;
  logic [3:0]        fail_vec_o [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    gf180mcu_fd_sc_mcu9t5v0__nand4_bist_if bus ();
    wire vdd_w = 1'b1;
    wire vss_w = 1'b0;

    assign bus.START = start_r[g];
    assign bus.ABORT = abort_r[g];
    assign bus.ZN_IN = resp_tab[g][{bus.A4, bus.A3, bus.A2, bus.A1}];

    gf180mcu_fd_sc_mcu9t5v0__nand4_bist #(.SETTLE(g + 1)) u_dut (
      .CLK (clk),
      .RN  (rst_n),
      .VDD (vdd_w),
      .VSS (vss_w),
      .bus (bus.slave)
    );

    assign a_o[g]        = {bus.A4, bus.A3, bus.A2, bus.A1};
    assign busy_o[g]     = bus.BUSY;
    assign done_o[g]     = bus.DONE;
    assign pass_o[g]     = bus.PASS;
    assign errcnt_o[g]   = bus.ERRCNT;
    assign fail_vld_o[g] = bus.FAIL_VLD;
    assign fail_vec_o[g] = bus.FAIL_VEC;
  end

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   launch_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popcount16(input logic [15:0] x);
    int c = 0;
    for (int b = 0; b < 16; b++) if (x[b]) c++;
    return c;
  endfunction

  // Reference: only the first n vectors were sampled. A mismatch is any
  // vector whose cell response differs from the ideal NAND truth table.
  function automatic exp_t predict(input int i, input logic [15:0] resp,
                                   input int n, input int c);
    exp_t        e;
    logic [15:0] mism;
    logic [15:0] seen;
    e      = '0;
    seen   = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
    mism   = (resp ^ IDEAL) & seen;
    e.inst = 2'(i);
    e.cyc  = 32'(c);
    for (int v = 15; v >= 0; v--) begin
      if (mism[v]) begin
        e.fail_vld = 1'b1;
        e.fail_vec = 4'(v);
      end
    end
    e.errcnt = 5'(popcount16(mism));
    e.pass   = (mism == 16'h0000);
    return e;
  endfunction

  // Pops one expectation on every rising DONE of any instance.
  task automatic monitor();
    logic [N_INST-1:0] done_prev;
    exp_t e;
    done_prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
        if (done_o[i] && !done_prev[i]) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: instance %0d raised DONE with nothing expected", i);
          end else begin
            e = exp_q.pop_front();
            check("done_inst",     32'(i),             32'(e.inst));
            check("done_cycle",    32'(cyc),           e.cyc);
            check("done_pass",     32'(pass_o[i]),     32'(e.pass));
            check("done_errcnt",   32'(errcnt_o[i]),   32'(e.errcnt));
            check("done_fail_vld", 32'(fail_vld_o[i]), 32'(e.fail_vld));
            check("done_fail_vec", 32'(fail_vec_o[i]), 32'(e.fail_vec));
            check("done_a_zero",   32'(a_o[i]),        32'd0);
            check("done_busy",     32'(busy_o[i]),     32'd0);
          end
        end
        done_prev[i] = done_o[i];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string name);
    for (int i = 0; i < N_INST; i++)
      check(name, 32'({a_o[i], busy_o[i], done_o[i], pass_o[i], errcnt_o[i],
                       fail_vld_o[i], fail_vec_o[i]}), 32'd0);
  endtask

  // Pulses START for one edge. Returns at the negedge after the start edge.
  task automatic launch(input int i, input logic [15:0] resp);
    resp_tab[i] = resp;
    start_r[i]  = 1'b1;
    launch_cyc  = cyc;
    @(negedge clk);
    start_r[i]  = 1'b0;
  endtask

  task automatic full_run(input int i, input logic [15:0] resp);
    int s;
    s = i + 1;
    launch(i, resp);
    exp_q.push_back(predict(i, resp, 16, launch_cyc + 1 + 16 * s));
    for (int t = 0; t < 16 * s; t++) begin
      check("run_vector", 32'(a_o[i]), 32'(t / s));
      check("run_busy",   32'(busy_o[i]), 32'd1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("done_hold", 32'(done_o[i]), 32'd1);
  endtask

  // ABORT is seen at start edge + a. Samples landing on that edge are lost.
  task automatic abort_run(input int i, input logic [15:0] resp, input int a);
    int   s;
    exp_t e;
    s = i + 1;
    launch(i, resp);
    repeat (a - 1) @(negedge clk);
    abort_r[i] = 1'b1;
    @(negedge clk);
    abort_r[i] = 1'b0;
    e = predict(i, resp, (a - 1) / s, 0);
    check("abort_ctrl",     32'({busy_o[i], done_o[i], pass_o[i], a_o[i]}), 32'd0);
    check("abort_errcnt",   32'(errcnt_o[i]),   32'(e.errcnt));
    check("abort_fail_vld", 32'(fail_vld_o[i]), 32'(e.fail_vld));
    check("abort_fail_vec", 32'(fail_vec_o[i]), 32'(e.fail_vec));
    repeat (3) @(negedge clk);
    check("abort_hold", 32'({busy_o[i], errcnt_o[i]}), 32'({1'b0, e.errcnt}));
  endtask

  task automatic held_start_test();
    int pulses;
    pulses      = 0;
    resp_tab[0] = IDEAL;
    start_r[0]  = 1'b1;
    launch_cyc  = cyc;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(predict(0, IDEAL, 16, launch_cyc + 17 + 17 * k));
    for (int m = 1; m <= 51; m++) begin
      @(negedge clk);
      if (done_o[0]) pulses++;
    end
    check("held_done_cycles", 32'(pulses), 32'd3);
    abort_r[0] = 1'b1;  // START still high at this DONE edge
    @(negedge clk);
    abort_r[0] = 1'b0;
    start_r[0] = 1'b0;
    check("held_abort", 32'({busy_o[0], done_o[0], pass_o[0], a_o[0]}), 32'd0);
    repeat (2) @(negedge clk);
    check("held_idle", 32'({busy_o[0], done_o[0]}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] mask;
    int          inst;
    rst_n   = 1'b0;
    start_r = '0;
    abort_r = '0;
    for (int i = 0; i < N_INST; i++) resp_tab[i] = IDEAL;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    fork
      monitor();
    join_none

    full_run(1, IDEAL);                           // SETTLE=2 ideal
    full_run(1, 16'hFFFF);                        // stuck at 1
    full_run(0, 16'h0000);                        // stuck at 0, SETTLE=1
    full_run(2, IDEAL ^ 16'h0220);                // V=5,9 wrong, SETTLE=3
    abort_run(2, IDEAL ^ 16'h0220, 20);
    abort_run(1, 16'h0000, 32);                   // abort beats final sample

    // Asynchronous reset between edges, during a run with errors logged.
    launch(1, IDEAL ^ 16'h0001);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
    full_run(1, IDEAL);

    held_start_test();

    for (int r = 0; r < 12; r++) begin
      inst = $urandom_range(0, N_INST - 1);
      case ($urandom_range(0, 3))
        0:       mask = 16'h0000;
        1:       mask = 16'($urandom);
        2:       mask = 16'(32'd1 << $urandom_range(0, 15));
        default: mask = 16'hFFFF;
      endcase
      if ($urandom_range(0, 1) == 0)
        full_run(inst, IDEAL ^ mask);
      else
        abort_run(inst, IDEAL ^ mask, $urandom_range(1, 16 * (inst + 1)));
    end

    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_vec++;
      n_bad++;
      $display("FAIL missing_done: expected DONE never arrived");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__nand4_bist.md
GF180MCU_FD_SC_MCU9T5V0__NAND4_BIST -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__nand4_bist

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles each test vector is held before ZN_IN is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RN  input  1  reset, asynchronous, active-low.
REQ-004 VDD, VSS  inout  1  supply pins; no logical function.
REQ-005 START  input  1  request a test run; sampled in IDLE or DONE state only.
REQ-006 ABORT  input  1  synchronous run cancel.
REQ-007 ZN_IN  input  1  observed output of the NAND4 under test.
REQ-008 A1, A2, A3, A4  output  1 each  registered stimulus driven to the NAND4 under test.
REQ-009 BUSY  output  1  run in progress.
REQ-010 DONE  output  1  run completed; results valid.
REQ-011 PASS  output  1  completed run had zero mismatches.
REQ-012 ERRCNT  output  5  mismatch count, 0..16.
REQ-013 FAIL_VLD  output  1  at least one mismatch captured.
REQ-014 FAIL_VEC  output  4  first failing vector, {A4,A3,A2,A1}.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 The vector index V SHALL be 4 bits; {A4,A3,A2,A1} SHALL equal V while in RUN.
REQ-017 Expected response SHALL be ~(A1&A2&A3&A4): 1 for V=0..14, 0 for V=15.
REQ-018 IDLE or DONE with START=1 and ABORT=0 at edge Es: enter RUN, V=0, BUSY=1, DONE=0, PASS=0, ERRCNT=0, FAIL_VLD=0, FAIL_VEC=0.
REQ-019 In RUN, ZN_IN SHALL be sampled at every edge Es+k*SETTLE, k=1..16, against the vector driven during the preceding SETTLE cycles.
REQ-020 At each sample edge, V SHALL advance by 1, except after V=15.
REQ-021 On a mismatch, ERRCNT SHALL increment by 1; no saturation, since the maximum is 16.
REQ-022 On the first mismatch of a run, FAIL_VLD SHALL be set to 1 and FAIL_VEC SHALL capture V; later mismatches SHALL NOT change FAIL_VEC.
REQ-023 At edge Es+16*SETTLE (sample of V=15), the FSM SHALL enter DONE.
REQ-024 On entry to DONE: BUSY=0, DONE=1, A1..A4=0, and PASS=1 iff the final ERRCNT (including this sample) is 0.
REQ-025 DONE and all results SHALL hold until the next accepted START, ABORT, or reset.
REQ-026 START SHALL be ignored while in RUN.
REQ-027 START held high continuously SHALL make DONE high for exactly one cycle, then restart per REQ-018.
REQ-028 ABORT=1 at any edge, in any state: go to IDLE, BUSY=0, DONE=0, PASS=0, A1..A4=0; ERRCNT, FAIL_VLD and FAIL_VEC hold their values.
REQ-029 ABORT SHALL take priority over START and over a coincident final sample.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-031 RN=0 SHALL immediately force: state IDLE, V=0, A1..A4=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAIL_VLD=0, FAIL_VEC=0, independent of CLK.
REQ-032 Reset asserted mid-run SHALL discard the run.
REQ-033 After RN deasserts, the first edge SHALL be treated as an IDLE edge.

Verification
REQ-034 SETTLE=2, ideal model ZN_IN=~&{A}, START pulse at edge 0: DONE=1 after edge 32, PASS=1, ERRCNT=0, FAIL_VLD=0, A=0000.
REQ-035 ZN_IN stuck at 1: ERRCNT=1, FAIL_VLD=1, FAIL_VEC=4'hF, PASS=0.
REQ-036 ZN_IN stuck at 0, SETTLE=1: DONE after edge 16, ERRCNT=15, FAIL_VEC=4'h0, PASS=0.
REQ-037 SETTLE=3, ZN_IN inverted only for V=5 and V=9: ERRCNT=2, FAIL_VEC=4'h5; ABORT pulsed at edge 20 of a repeat run gives IDLE, BUSY=0, DONE=0, and ERRCNT holds its accumulated value.
REQ-038 RN pulsed low mid-run, between edges: all outputs zero with no clock edge; START after release gives a clean full run.
REQ-039 START held high, ideal model, SETTLE=1: DONE high for one cycle every 17 cycles; ABORT and START both high at the DONE edge gives IDLE.
